// File: rtl/rx_pkt_word_packer.sv
// rx_pkt_word_packer
//
// Packs the decoded PSDU byte stream from the dot11 receiver into 64-bit
// little-endian words, queues them in a first-word-fall-through FIFO and
// presents them on a valid/ready stream toward the RX DMA. Every packet is
// closed by a trailer word (length, sequence number, status) marked with
// m_tlast.
//
// Ports
//   clock                   system clock
//   reset                   synchronous, active-high reset
//   enable                  gates all input strobes (output still drains)
//   pkt_header_valid_strobe new packet starts, pkt_len valid
//   pkt_len [15:0]          PSDU length in bytes (FCS included)
//   byte_in [7:0]           decoded byte, qualified by byte_in_strobe
//   fcs_out_strobe          fcs_ok valid this cycle
//   fcs_ok                  1 = CRC passed
//   m_tdata [63:0]          output word
//   m_tvalid / m_tready     output handshake
//   m_tlast                 high on trailer words
//   overflow_cnt [15:0]     saturating count of dropped data words
//   pkt_sn [SN_W-1:0]       sequence number the next trailer will carry
//
// Trailer word: [15:0] length, [15+SN_W:16] sequence number, [48] fcs_ok,
// [49] data dropped, [50] aborted, all other bits zero.

module rx_pkt_word_packer #(
    parameter int FIFO_AW = 5,
    parameter int SN_W    = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic            pkt_header_valid_strobe,
    input  logic [15:0]     pkt_len,
    input  logic [7:0]      byte_in,
    input  logic            byte_in_strobe,
    input  logic            fcs_out_strobe,
    input  logic            fcs_ok,
    output logic [63:0]     m_tdata,
    output logic            m_tvalid,
    input  logic            m_tready,
    output logic            m_tlast,
    output logic [15:0]     overflow_cnt,
    output logic [SN_W-1:0] pkt_sn
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, COLLECT, WAIT_FCS, TRAILER} state_t;

    // ---------------- packer / FSM state ----------------
    state_t          state_reg;
    logic [15:0]     len_reg;
    logic [15:0]     byte_cnt_reg;
    logic [63:0]     pack_reg;
    logic [2:0]      lane_reg;
    logic            drop_reg;
    logic            fcs_seen_reg;
    logic            fcs_ok_reg;
    logic            wpend_reg;      // completed data word waiting to be pushed
    logic [63:0]     wdata_reg;
    logic            abort_pend_reg; // aborted-packet trailer waiting to be pushed
    logic [15:0]     abort_len_reg;
    logic            abort_drop_reg;
    logic [SN_W-1:0] sn_reg;
    logic [15:0]     ovf_reg;

    // ---------------- FIFO state ----------------
    // cnt_reg counts every stored word including the one in the output
    // register, so the capacity seen by the reservation logic is DEPTH.
    logic [64:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_reg;
    logic [FIFO_AW-1:0] rd_ptr_reg;
    logic [CW-1:0]      cnt_reg;
    logic               out_valid_reg;
    logic [64:0]        out_word_reg;

    // ---------------- qualified inputs ----------------
    logic hdr, byte_v, fcs_v;
    assign hdr    = enable & pkt_header_valid_strobe;
    assign byte_v = enable & byte_in_strobe;
    assign fcs_v  = enable & fcs_out_strobe;

    // ---------------- FIFO occupancy / write arbitration ----------------
    logic          pop;
    logic [CW:0]   free_slots;
    logic          has1, has2;
    logic          abort_wr, norm_trl_wr, trl_wr, data_wr, data_drop, push;
    logic [64:0]   push_word;
    logic [63:0]   trl_word;

    assign pop        = out_valid_reg & m_tready;
    assign free_slots = DEPTH_V - {1'b0, cnt_reg} + {{CW{1'b0}}, pop};
    assign has1       = free_slots >= (CW + 1)'(1);
    assign has2       = free_slots >= (CW + 1)'(2);

    // The aborted trailer goes first so trailer order matches packet order.
    assign abort_wr    = abort_pend_reg & has1;
    assign norm_trl_wr = (state_reg == TRAILER) & ~abort_pend_reg & has1;
    assign trl_wr      = abort_wr | norm_trl_wr;
    // Data needs two free slots so the packet's trailer always has room.
    assign data_wr     = wpend_reg & ~trl_wr & has2;
    assign data_drop   = wpend_reg & ~data_wr;
    assign push        = trl_wr | data_wr;

    always_comb begin
        trl_word           = '0;
        trl_word[15:0]     = abort_wr ? abort_len_reg : len_reg;
        trl_word[16 +: SN_W] = sn_reg;
        trl_word[48]       = abort_wr ? 1'b0 : fcs_ok_reg;
        trl_word[49]       = abort_wr ? abort_drop_reg : drop_reg;
        trl_word[50]       = abort_wr;
        push_word          = trl_wr ? {1'b1, trl_word} : {1'b0, wdata_reg};
    end

    // ---------------- byte lane insertion ----------------
    logic [63:0] pack_with;
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign pack_with[8*gi +: 8] = (lane_reg == 3'(gi)) ? byte_in
                                                                : pack_reg[8*gi +: 8];
        end
    endgenerate

    logic last_byte, start_pkt, abort_pkt;
    assign last_byte = byte_cnt_reg == (len_reg - 16'd1);
    assign abort_pkt = hdr & ((state_reg == COLLECT) | (state_reg == WAIT_FCS));
    // A header arriving in the cycle the trailer goes out starts the next
    // packet immediately; while the trailer is still blocked it is ignored.
    assign start_pkt = hdr & ((state_reg == IDLE) | abort_pkt |
                              ((state_reg == TRAILER) & norm_trl_wr));

    // ---------------- FSM and packer ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            len_reg        <= '0;
            byte_cnt_reg   <= '0;
            pack_reg       <= '0;
            lane_reg       <= '0;
            drop_reg       <= 1'b0;
            fcs_seen_reg   <= 1'b0;
            fcs_ok_reg     <= 1'b0;
            wpend_reg      <= 1'b0;
            wdata_reg      <= '0;
            abort_pend_reg <= 1'b0;
            abort_len_reg  <= '0;
            abort_drop_reg <= 1'b0;
            sn_reg         <= '0;
            ovf_reg        <= '0;
        end else begin
            wpend_reg <= 1'b0;
            if (data_drop) begin
                drop_reg <= 1'b1;
                if (ovf_reg != 16'hFFFF) ovf_reg <= ovf_reg + 16'd1;
            end
            if (trl_wr)   sn_reg <= sn_reg + SN_W'(1);
            if (abort_wr) abort_pend_reg <= 1'b0;

            case (state_reg)
                IDLE: ;
                COLLECT: begin
                    if (!hdr) begin
                        if (fcs_v) begin
                            fcs_seen_reg <= 1'b1;
                            fcs_ok_reg   <= fcs_ok;
                        end
                        if (byte_v) begin
                            byte_cnt_reg <= byte_cnt_reg + 16'd1;
                            if (lane_reg == 3'd7 || last_byte) begin
                                wpend_reg <= 1'b1;
                                wdata_reg <= pack_with;
                                pack_reg  <= '0;
                                lane_reg  <= '0;
                            end else begin
                                pack_reg <= pack_with;
                                lane_reg <= lane_reg + 3'd1;
                            end
                            if (last_byte) state_reg <= WAIT_FCS;
                        end
                    end
                end
                WAIT_FCS: begin
                    if (!hdr) begin
                        if (fcs_v) begin
                            fcs_ok_reg <= fcs_ok;
                            state_reg  <= TRAILER;
                        end else if (fcs_seen_reg) begin
                            state_reg <= TRAILER;
                        end
                    end
                end
                TRAILER: begin
                    if (norm_trl_wr) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase

            // Capture the old packet's status before start_pkt clears it;
            // a data word dropped this very cycle still belongs to it.
            if (abort_pkt) begin
                abort_pend_reg <= 1'b1;
                abort_len_reg  <= len_reg;
                abort_drop_reg <= drop_reg | data_drop;
            end
            if (start_pkt) begin
                len_reg      <= pkt_len;
                byte_cnt_reg <= '0;
                pack_reg     <= '0;
                lane_reg     <= '0;
                drop_reg     <= 1'b0;
                fcs_seen_reg <= 1'b0;
                fcs_ok_reg   <= 1'b0;
                state_reg    <= (pkt_len == 16'd0) ? WAIT_FCS : COLLECT;
            end
        end
    end

    // ---------------- FWFT FIFO ----------------
    logic          load_out, mem_empty, bypass;
    logic [CW-1:0] mem_cnt;

    assign load_out  = ~out_valid_reg | pop;
    assign mem_cnt   = cnt_reg - {{(CW-1){1'b0}}, out_valid_reg};
    assign mem_empty = mem_cnt == '0;
    // Word goes straight into the output register when nothing is ahead of it.
    assign bypass    = push & load_out & mem_empty;

    always_ff @(posedge clock) begin
        if (push && !bypass) mem[wr_ptr_reg] <= push_word;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_word_reg  <= '0;
        end else begin
            if (push && !bypass) wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
            cnt_reg <= cnt_reg + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
            if (load_out) begin
                if (!mem_empty) begin
                    out_word_reg  <= mem[rd_ptr_reg];
                    rd_ptr_reg    <= rd_ptr_reg + FIFO_AW'(1);
                    out_valid_reg <= 1'b1;
                end else if (push) begin
                    out_word_reg  <= push_word;
                    out_valid_reg <= 1'b1;
                end else begin
                    out_valid_reg <= 1'b0;
                end
            end
        end
    end

    assign m_tdata      = out_word_reg[63:0];
    assign m_tlast      = out_word_reg[64];
    assign m_tvalid     = out_valid_reg;
    assign overflow_cnt = ovf_reg;
    assign pkt_sn       = sn_reg;

endmodule

// File: tb/tb_rx_pkt_word_packer.sv
// Directed testbench for rx_pkt_word_packer. Inputs change 2 time units
// after the rising edge; output beats are captured on the falling edge.

module tb_rx_pkt_word_packer;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        pkt_header_valid_strobe;
    logic [15:0] pkt_len;
    logic [7:0]  byte_in;
    logic        byte_in_strobe;
    logic        fcs_out_strobe;
    logic        fcs_ok;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [15:0] overflow_cnt;
    logic [15:0] pkt_sn;

    int errors = 0;
    int checks = 0;
    logic [64:0] beats[$];

    rx_pkt_word_packer #(.FIFO_AW(5), .SN_W(16)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .enable                  (enable),
        .pkt_header_valid_strobe (pkt_header_valid_strobe),
        .pkt_len                 (pkt_len),
        .byte_in                 (byte_in),
        .byte_in_strobe          (byte_in_strobe),
        .fcs_out_strobe          (fcs_out_strobe),
        .fcs_ok                  (fcs_ok),
        .m_tdata                 (m_tdata),
        .m_tvalid                (m_tvalid),
        .m_tready                (m_tready),
        .m_tlast                 (m_tlast),
        .overflow_cnt            (overflow_cnt),
        .pkt_sn                  (pkt_sn)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (m_tvalid && m_tready) beats.push_back({m_tlast, m_tdata});
    end

    initial begin
        #1500000;
        $display("FAIL timeout observed=no finish expected=finish");
        $fatal(1, "timeout");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [63:0] exp_data, input logic exp_last);
        logic [64:0] b;
        checks++;
        assert (beats.size() > 0) else begin
            errors++;
            $error("FAIL %s observed=no beat expected=%h last=%0b", tag, exp_data, exp_last);
        end
        if (beats.size() > 0) begin
            b = beats.pop_front();
            $display("beat %s data=%h last=%0b", tag, b[63:0], b[64]);
            assert (b === {exp_last, exp_data}) else begin
                errors++;
                $error("FAIL %s observed=%h/%0b expected=%h/%0b", tag, b[63:0], b[64], exp_data, exp_last);
            end
        end
    endtask

    task automatic header(input logic [15:0] len);
        pkt_header_valid_strobe = 1'b1;
        pkt_len = len;
        step(1);
        pkt_header_valid_strobe = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in = b;
        byte_in_strobe = 1'b1;
        step(1);
        byte_in_strobe = 1'b0;
    endtask

    task automatic fcs(input logic ok);
        fcs_out_strobe = 1'b1;
        fcs_ok = ok;
        step(1);
        fcs_out_strobe = 1'b0;
    endtask

    initial begin
        logic [63:0] w;
        reset = 1'b1; enable = 1'b1; pkt_header_valid_strobe = 1'b0; pkt_len = '0;
        byte_in = '0; byte_in_strobe = 1'b0; fcs_out_strobe = 1'b0; fcs_ok = 1'b0;
        m_tready = 1'b1;
        step(3);
        chk("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
        chk("rst_tlast", {63'd0, m_tlast}, 64'd0);
        chk("rst_ovf", {48'd0, overflow_cnt}, 64'd0);
        chk("rst_sn", {48'd0, pkt_sn}, 64'd0);
        reset = 1'b0;
        step(1);

        // 12-byte packet, FCS ok
        header(16'd12);
        for (int i = 1; i <= 12; i++) send_byte(8'(i));
        fcs(1'b1);
        step(6);
        chk_beat("p12_w0", 64'h0807060504030201, 1'b0);
        chk_beat("p12_w1", 64'h000000000C0B0A09, 1'b0);
        chk_beat("p12_trl", 64'h0001_0000_0000_000C, 1'b1);
        chk("p12_sn", {48'd0, pkt_sn}, 64'd1);

        // 8-byte packet, FCS strobe with the last byte, FCS bad
        header(16'd8);
        for (int i = 0; i < 7; i++) send_byte(8'(8'h11 + i));
        byte_in = 8'h18; byte_in_strobe = 1'b1; fcs_out_strobe = 1'b1; fcs_ok = 1'b0;
        step(1);
        byte_in_strobe = 1'b0; fcs_out_strobe = 1'b0;
        step(6);
        chk_beat("p8_w0", 64'h1817161514131211, 1'b0);
        chk_beat("p8_trl", 64'h0000_0000_0001_0008, 1'b1);
        chk("p8_sn", {48'd0, pkt_sn}, 64'd2);

        // 400-byte packet against a stalled sink: overflow and reservation
        m_tready = 1'b0;
        header(16'd400);
        for (int i = 0; i < 400; i++) begin
            if (i == 8) chk("ovf_tvalid_before_push", {63'd0, m_tvalid}, 64'd0);
            if (i == 9) chk("ovf_tvalid_after_push", {63'd0, m_tvalid}, 64'd1);
            send_byte(8'(i));
        end
        fcs(1'b1);
        step(5);
        chk("ovf_cnt", {48'd0, overflow_cnt}, 64'd19);
        chk("ovf_hold_valid", {63'd0, m_tvalid}, 64'd1);
        chk("ovf_hold_data", m_tdata, 64'h0706050403020100);
        chk("ovf_no_beats", 64'(beats.size()), 64'd0);
        chk("ovf_sn", {48'd0, pkt_sn}, 64'd3);
        m_tready = 1'b1;
        step(40);
        chk("ovf_beat_count", 64'(beats.size()), 64'd32);
        for (int wi = 0; wi < 31; wi++) begin
            for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'(8*wi + k);
            chk_beat($sformatf("ovf_w%0d", wi), w, 1'b0);
        end
        chk_beat("ovf_trl", 64'h0003_0000_0002_0190, 1'b1);
        chk("ovf_drained", {63'd0, m_tvalid}, 64'd0);

        // abort after 5 bytes of a 20-byte packet, new packet of 4 bytes
        header(16'd20);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h51 + i));
        pkt_header_valid_strobe = 1'b1; pkt_len = 16'd4;
        byte_in = 8'hEE; byte_in_strobe = 1'b1;
        step(1);
        pkt_header_valid_strobe = 1'b0; byte_in_strobe = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'(8'hA1 + i));
        fcs(1'b1);
        step(6);
        chk_beat("abt_trl", 64'h0004_0000_0003_0014, 1'b1);
        chk_beat("abt_new_w0", 64'h00000000A4A3A2A1, 1'b0);
        chk_beat("abt_new_trl", 64'h0001_0000_0004_0004, 1'b1);
        chk("abt_ovf", {48'd0, overflow_cnt}, 64'd19);
        chk("abt_sn", {48'd0, pkt_sn}, 64'd5);

        // enable low: header and FCS ignored
        enable = 1'b0;
        header(16'd0);
        fcs(1'b1);
        step(4);
        enable = 1'b1;
        chk("en_no_beats", 64'(beats.size()), 64'd0);
        chk("en_sn", {48'd0, pkt_sn}, 64'd5);

        // zero-length packet: trailer only
        header(16'd0);
        step(3);
        chk("z_wait", 64'(beats.size()), 64'd0);
        fcs(1'b1);
        step(4);
        chk_beat("z_trl", 64'h0001_0000_0005_0000, 1'b1);
        chk("z_sn", {48'd0, pkt_sn}, 64'd6);

        // reset in the middle of a packet
        m_tready = 1'b0;
        header(16'd16);
        for (int i = 0; i < 10; i++) send_byte(8'(i));
        step(2);
        chk("mrst_pre_valid", {63'd0, m_tvalid}, 64'd1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("mrst_tvalid", {63'd0, m_tvalid}, 64'd0);
        chk("mrst_tlast", {63'd0, m_tlast}, 64'd0);
        chk("mrst_sn", {48'd0, pkt_sn}, 64'd0);
        chk("mrst_ovf", {48'd0, overflow_cnt}, 64'd0);
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++) send_byte(8'(i));
        step(5);
        chk("mrst_empty", 64'(beats.size()), 64'd0);
        chk("mrst_still_idle", {63'd0, m_tvalid}, 64'd0);

        // sequence number wrap: header held high aborts one packet per cycle
        beats.delete();
        pkt_header_valid_strobe = 1'b1; pkt_len = 16'd0;
        step(65536);
        pkt_header_valid_strobe = 1'b0;
        step(3);
        chk("wrap_sn_max", {48'd0, pkt_sn}, 64'h0000_0000_0000_FFFF);
        fcs(1'b1);
        step(3);
        chk("wrap_sn_zero", {48'd0, pkt_sn}, 64'd0);
        header(16'd0);
        fcs(1'b1);
        step(3);
        chk("wrap_sn_one", {48'd0, pkt_sn}, 64'd1);
        chk("wrap_beat_count", 64'(beats.size()), 64'd65537);
        if (beats.size() >= 3) begin
            chk("wrap_prev_trl", beats[beats.size() - 2][63:0], 64'h0001_0000_FFFF_0000);
            chk("wrap_last_trl", beats[beats.size() - 1][63:0], 64'h0001_0000_0000_0000);
        end
        chk_beat("wrap_first_trl", 64'h0004_0000_0000_0000, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_pkt_word_packer.md
Name: rx_pkt_word_packer

Overview:
- Sits directly downstream of the dot11 receiver.
- Consumes the decoded PSDU byte stream (byte_out/byte_out_strobe), pkt_len from the header strobe, and the FCS result.
- Packs bytes into 64-bit little-endian words, buffers them in a FIFO, and delivers them over a valid/ready stream toward the RX DMA.
- Each packet ends with a trailer word carrying length, sequence number and status.

Parameters:
- FIFO_AW, 5, log2 of FIFO depth in 64-bit words (depth 32).
- SN_W, 16, width of the packet sequence counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  when low, input strobes are ignored; the output stream still drains.
- pkt_header_valid_strobe  in  1  one-cycle pulse: a new packet starts; pkt_len is valid.
- pkt_len  in  16  PSDU length in bytes, including the FCS.
- byte_in  in  8  decoded byte.
- byte_in_strobe  in  1  byte_in valid this cycle.
- fcs_out_strobe  in  1  one-cycle pulse: fcs_ok is valid.
- fcs_ok  in  1  1 = CRC passed.
- m_tdata  out  64  output word.
- m_tvalid  out  1  output word valid.
- m_tready  in  1  sink accepts the word when m_tvalid && m_tready.
- m_tlast  out  1  high on the trailer word.
- overflow_cnt  out  16  saturating count of dropped data words.
- pkt_sn  out  SN_W  sequence number of the next trailer.

Behaviour:
- Reset: all outputs are 0 (m_tvalid=0, m_tlast=0, overflow_cnt=0, pkt_sn=0), the FIFO is empty, state is IDLE, the pack register is cleared. A reset mid-packet discards everything.
- States:
  - IDLE: waits for the header strobe.
  - COLLECT: packs bytes.
  - WAIT_FCS: all pkt_len bytes received, waiting for the FCS result.
  - TRAILER: pushes the trailer word.
- Transitions:
  - IDLE -> COLLECT on the header strobe. Latch pkt_len, clear byte count, pack register, lane index and drop flag.
  - If pkt_len==0: IDLE -> WAIT_FCS directly.
  - COLLECT -> WAIT_FCS once the last byte has been accepted.
  - If fcs_out_strobe arrives in the same cycle as the last byte, or at any point before WAIT_FCS, latch fcs_ok and a fcs_seen flag; WAIT_FCS then goes straight to TRAILER.
  - WAIT_FCS -> TRAILER on fcs_out_strobe or when fcs_seen is set.
  - TRAILER -> IDLE after a 1-cycle push. The trailer always fits (reservation rule below).
  - A header strobe in COLLECT or WAIT_FCS aborts the current packet:
    - discard the partial word;
    - push a trailer with aborted=1 and fcs_ok=0;
    - next cycle, start the new packet in COLLECT with the new pkt_len latched at the strobe.
    - Any byte_in_strobe in the abort cycle is ignored.
- Packing:
  - The k-th byte of a word goes to bits [8k+7:8k].
  - A word is written to the FIFO the cycle after its 8th byte, or after the packet's final byte if the word is partial.
  - Unused lanes of a partial word are 0.
  - Number of data words per packet = ceil(pkt_len/8).
- FIFO:
  - First-word-fall-through.
  - m_tvalid rises 1 cycle after the first write into an empty FIFO.
  - A simultaneous push and pop is allowed at any fill level.
- Reservation rule:
  - A data word is pushed only if free entries >= 2 (pop in the same cycle counts as freeing one). Otherwise the word is dropped, the drop flag is set, and overflow_cnt increments (saturating at 0xFFFF).
  - This guarantees one free slot for the trailer.
- Trailer layout:
  - [15:0] pkt_len as latched.
  - [15+SN_W:16] pkt_sn.
  - [48] fcs_ok.
  - [49] drop flag.
  - [50] aborted.
  - All other bits 0.
  - m_tlast=1 on the trailer only.
- pkt_sn increments by 1 when the trailer is pushed and wraps from all-ones to 0.
- Byte strobes in IDLE, WAIT_FCS or TRAILER are ignored. Extra bytes beyond pkt_len are ignored.
- Output stream rules:
  - m_tdata, m_tvalid and m_tlast must stay stable while m_tvalid && !m_tready.
  - Back-pressure never stalls input acceptance; excess data is dropped per the reservation rule.

Test Plan:
- Header pkt_len=12, bytes 0x01..0x0C, fcs_ok=1, m_tready=1:
  - 0x0807060504030201;
  - 0x000000000C0B0A09;
  - trailer 0x0001_0000_0000_000C with m_tlast=1;
  - pkt_sn becomes 1.
- pkt_len=8 with fcs_out_strobe in the same cycle as the 8th byte, fcs_ok=0 -> one data word, then trailer bit48=0; no deadlock in WAIT_FCS.
- m_tready=0 for the whole packet, pkt_len=400 (50 words) with FIFO_AW=5:
  - 31 data words are stored, 19 dropped;
  - overflow_cnt=19;
  - trailer bit49=1 and is present as the 32nd FIFO entry;
  - release m_tready -> exactly 32 beats, the last with m_tlast.
- Second header strobe after 5 bytes of a pkt_len=20 packet, new pkt_len=4:
  - aborted trailer (bit50=1, length 20) with no data word;
  - then the new packet: 1 data word, then trailer length 4.
- pkt_len=0, then fcs_out_strobe -> only the trailer is emitted.
- Run 65537 packets -> pkt_sn wraps to 0 and then reads 1.
- Assert reset mid-packet -> m_tvalid=0 the next cycle, FIFO empty, pkt_sn=0.
